// File: rtl/stopwatch_lap_dp.sv
// ============================================================================
// stopwatch_lap_dp : run-gated prescaler, up/down hh:mm:ss.cc time counter
//                    and first-word-fall-through lap timestamp FIFO
// Revision 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module stopwatch_lap_dp #(
    parameter  int CLK_HZ    = 100_000_000,
    parameter  int TICK_HZ   = 100,
    parameter  int HOUR_MAX  = 24,
    parameter  int LAP_DEPTH = 4,
    localparam int HW        = $clog2(HOUR_MAX),
    localparam int CW        = $clog2(LAP_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_run,
    input  logic            i_clear,
    input  logic            i_down,
    input  logic            i_lap,
    input  logic            i_lap_rd,
    output logic [6:0]      o_msec,
    output logic [5:0]      o_sec,
    output logic [5:0]      o_min,
    output logic [HW-1:0]   o_hour,
    output logic [HW+18:0]  o_lap_time,
    output logic            o_lap_valid,
    output logic [CW-1:0]   o_lap_count,
    output logic            o_lap_ovf,
    output logic            o_wrap,
    output logic            o_done
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(LAP_DEPTH);
    localparam int TW  = HW + 19;
    localparam logic [HW-1:0] C_HOUR_LAST = HW'(HOUR_MAX - 1);

    logic           w_kill;
    assign w_kill = rst | i_clear;

    // ---------------- prescaler ----------------
    logic [PCW-1:0] pc_q;
    logic           tick_q;
    logic           w_pc_last;
    assign w_pc_last = (pc_q == PCW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (w_kill) begin
            pc_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= i_run & w_pc_last;
            if (i_run)
                pc_q <= w_pc_last ? '0 : pc_q + PCW'(1);
        end
    end

    // ---------------- time counter ----------------
    logic [6:0]    msec_q, msec_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [HW-1:0] hour_q, hour_d;
    logic          wrap_q;
    logic          w_all_zero, w_all_max;

    assign w_all_zero = (msec_q == 7'd0) && (sec_q == 6'd0) && (min_q == 6'd0) && (hour_q == '0);
    assign w_all_max  = (msec_q == 7'd99) && (sec_q == 6'd59) && (min_q == 6'd59) && (hour_q == C_HOUR_LAST);

    // Every digit's next value is resolved here so the whole time word moves on one edge.
    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (tick_q && !i_down) begin
            if (msec_q == 7'd99) begin
                msec_d = 7'd0;
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d  = 6'd0;
                        hour_d = (hour_q == C_HOUR_LAST) ? '0 : hour_q + HW'(1);
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                msec_d = msec_q + 7'd1;
            end
        end else if (tick_q && i_down && !w_all_zero) begin
            if (msec_q == 7'd0) begin
                msec_d = 7'd99;
                if (sec_q == 6'd0) begin
                    sec_d = 6'd59;
                    if (min_q == 6'd0) begin
                        min_d  = 6'd59;
                        hour_d = hour_q - HW'(1);
                    end else begin
                        min_d = min_q - 6'd1;
                    end
                end else begin
                    sec_d = sec_q - 6'd1;
                end
            end else begin
                msec_d = msec_q - 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_kill) begin
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            msec_q <= msec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            wrap_q <= tick_q & ~i_down & w_all_max;
        end
    end

    // ---------------- lap FIFO ----------------
    logic [TW-1:0] lap_mem_q [LAP_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] lap_cnt_q;
    logic          ovf_q;
    logic          w_full, w_empty, w_push, w_pop, w_drop;
    logic [TW-1:0] w_now;

    assign w_now   = {hour_q, min_q, sec_q, msec_q};
    assign w_full  = (lap_cnt_q == CW'(LAP_DEPTH));
    assign w_empty = (lap_cnt_q == '0);
    assign w_pop   = i_lap_rd & ~w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign w_push  = i_lap & (~w_full | w_pop);
    assign w_drop  = i_lap & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!w_kill && w_push)
            lap_mem_q[wr_ptr_q] <= w_now;
    end

    always_ff @(posedge clk) begin
        if (w_kill) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lap_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (w_push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (w_push && !w_pop)
                lap_cnt_q <= lap_cnt_q + CW'(1);
            else if (w_pop && !w_push)
                lap_cnt_q <= lap_cnt_q - CW'(1);
            if (w_drop)
                ovf_q <= 1'b1;
        end
    end

    assign o_msec      = msec_q;
    assign o_sec       = sec_q;
    assign o_min       = min_q;
    assign o_hour      = hour_q;
    assign o_lap_time  = w_empty ? '0 : lap_mem_q[rd_ptr_q];
    assign o_lap_valid = ~w_empty;
    assign o_lap_count = lap_cnt_q;
    assign o_lap_ovf   = ovf_q;
    assign o_wrap      = wrap_q;
    assign o_done      = i_down & w_all_zero;

endmodule

`default_nettype wire
